// File: rtl/pixel_gen_pkg.sv
// Shared constants for the ball game pixel generator: colours, FSM states,
// default screen size and the round-ball mask.
package pixel_gen_pkg;

    localparam int HD_DEFAULT = 640;
    localparam int VD_DEFAULT = 480;

    localparam logic [11:0] COL_WALL = 12'h00F;
    localparam logic [11:0] COL_PAD  = 12'h0F0;
    localparam logic [11:0] COL_BALL = 12'hF00;
    localparam logic [11:0] COL_BG   = 12'h000;

    typedef enum logic {
        PLAY      = 1'b0,
        MISS_WAIT = 1'b1
    } game_state_t;

    // 8x8 circle, row 0 in the top byte, column 0 in bit 7 of each byte.
    localparam logic [63:0] BALL_MASK = 64'h3C7E_FFFF_FFFF_7E3C;

endpackage

// File: rtl/ball_rom.sv
// Combinational 8x8 circle mask lookup: row address in, one mask row out.
// Only instantiated when BALL_ROUND_EN is defined.
module ball_rom
    import pixel_gen_pkg::*;
(
    input  logic [2:0] i_row,
    output logic [7:0] o_mask
);

    assign o_mask = BALL_MASK[{3'd7 - i_row, 3'b000} +: 8];

endmodule

// File: rtl/pixel_gen_ball.sv
// Wall / paddle / bouncing-ball pixel generator for 640x480 VGA, with game
// state updated once per frame. Optional round ball via macro BALL_ROUND_EN.
module pixel_gen_ball
    import pixel_gen_pkg::*;
#(
    parameter int HD          = HD_DEFAULT,
    parameter int VD          = VD_DEFAULT,
    parameter int WALL_X_L    = 32,
    parameter int WALL_X_R    = 39,
    parameter int PAD_X_L     = 600,
    parameter int PAD_X_R     = 603,
    parameter int PAD_H       = 72,
    parameter int PAD_V       = 3,
    parameter int BALL_SIZE   = 8,
    parameter int BALL_V      = 2,
    parameter int MISS_FRAMES = 60
) (
    input  logic        clk_100MHz,
    input  logic        reset_n,
    input  logic        video_on,
    input  logic        p_tick,
    input  logic        refresh_tick,
    input  logic [9:0]  x,
    input  logic [9:0]  y,
    input  logic        btn_up,
    input  logic        btn_down,
    output logic [11:0] rgb,
    output logic        miss
);

    localparam int CNT_W = $clog2(MISS_FRAMES);

    localparam logic [9:0] L_WALL_X_L  = 10'(WALL_X_L);
    localparam logic [9:0] L_WALL_X_R  = 10'(WALL_X_R);
    localparam logic [9:0] L_PAD_X_L   = 10'(PAD_X_L);
    localparam logic [9:0] L_PAD_X_R   = 10'(PAD_X_R);
    localparam logic [9:0] L_PAD_EXT   = 10'(PAD_H - 1);
    localparam logic [9:0] L_PAD_V     = 10'(PAD_V);
    localparam logic [9:0] L_PAD_MAX   = 10'(VD - PAD_H);
    localparam logic [9:0] L_PAD_Y0    = 10'((VD - PAD_H) / 2);
    localparam logic [9:0] L_BALL_SIZE = 10'(BALL_SIZE);
    localparam logic [9:0] L_BALL_EXT  = 10'(BALL_SIZE - 1);
    localparam logic [9:0] L_BALL_V    = 10'(BALL_V);
    localparam logic [9:0] L_BALL_X0   = 10'(HD / 2);
    localparam logic [9:0] L_BALL_Y0   = 10'(VD / 2);
    localparam logic [9:0] L_BOT_LIM   = 10'(VD - BALL_V);
    localparam logic [9:0] L_LEFT_LIM  = 10'(WALL_X_R + BALL_V + 1);
    localparam logic [9:0] L_HIT_L     = 10'(PAD_X_L - BALL_V);
    localparam logic [9:0] L_MISS_X    = 10'(HD - BALL_SIZE);
    localparam logic [CNT_W-1:0] L_CNT_LAST = CNT_W'(MISS_FRAMES - 1);

    // Registers
    logic [1:0]       r_up_sync;
    logic [1:0]       r_down_sync;
    logic             r_refresh_d;
    logic [9:0]       r_pad_y;
    game_state_t      r_state;
    logic [9:0]       r_ball_x;
    logic [9:0]       r_ball_y;
    logic             r_dx;
    logic             r_dy;
    logic [CNT_W-1:0] r_frame_cnt;
    logic             r_miss;
    logic [11:0]      r_rgb;

    // Combinational signals
    logic             w_frame_evt;
    logic             w_up;
    logic             w_down;
    logic [9:0]       w_pad_y_next;
    logic [9:0]       w_ball_x_r;
    logic [9:0]       w_ball_y_b;
    logic             w_row_overlap;
    logic             w_dx_new;
    logic             w_dy_new;
    logic [9:0]       w_x_moved;
    logic [9:0]       w_y_moved;
    game_state_t      w_state_next;
    logic [9:0]       w_ball_x_next;
    logic [9:0]       w_ball_y_next;
    logic             w_dx_next;
    logic             w_dy_next;
    logic [CNT_W-1:0] w_cnt_next;
    logic             w_miss_next;
    logic             w_wall_px;
    logic             w_pad_px;
    logic             w_ball_box;
    logic             w_ball_px;
    logic [11:0]      w_colour;

    assign w_up        = r_up_sync[1];
    assign w_down      = r_down_sync[1];
    assign w_frame_evt = refresh_tick && !r_refresh_d;

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge value of every other flop, independent of statement order.
    always_ff @(posedge clk_100MHz or negedge reset_n) begin
        if (!reset_n) begin
            r_up_sync   <= '0;
            r_down_sync <= '0;
            r_refresh_d <= 1'b0;
            r_pad_y     <= L_PAD_Y0;
        end else begin
            r_up_sync   <= {r_up_sync[0], btn_up};
            r_down_sync <= {r_down_sync[0], btn_down};
            r_refresh_d <= refresh_tick;
            r_pad_y     <= w_pad_y_next;
        end
    end

    always_comb begin
        w_pad_y_next = r_pad_y;
        if (w_frame_evt) begin
            if (w_up && !w_down) begin
                w_pad_y_next = (r_pad_y >= L_PAD_V) ? r_pad_y - L_PAD_V : '0;
            end else if (w_down && !w_up) begin
                w_pad_y_next = (r_pad_y + L_PAD_V > L_PAD_MAX) ? L_PAD_MAX
                                                               : r_pad_y + L_PAD_V;
            end
        end
    end

    // Ball extents and bounce decisions, evaluated against pre-move positions.
    assign w_ball_x_r    = r_ball_x + L_BALL_EXT;
    assign w_ball_y_b    = r_ball_y + L_BALL_EXT;
    assign w_row_overlap = (r_ball_y <= r_pad_y + L_PAD_EXT) && (w_ball_y_b >= r_pad_y);

    always_comb begin
        w_dy_new = r_dy;
        if (r_ball_y <= L_BALL_V) begin
            w_dy_new = 1'b1;
        end else if (r_ball_y + L_BALL_SIZE >= L_BOT_LIM) begin
            w_dy_new = 1'b0;
        end

        w_dx_new = r_dx;
        if (r_ball_x <= L_LEFT_LIM) begin
            w_dx_new = 1'b1;
        end else if (w_ball_x_r >= L_HIT_L && w_ball_x_r <= L_PAD_X_R && w_row_overlap) begin
            w_dx_new = 1'b0;
        end
    end

    assign w_x_moved = w_dx_new ? r_ball_x + L_BALL_V : r_ball_x - L_BALL_V;
    assign w_y_moved = w_dy_new ? r_ball_y + L_BALL_V : r_ball_y - L_BALL_V;

    always_ff @(posedge clk_100MHz or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= PLAY;
            r_ball_x    <= L_BALL_X0;
            r_ball_y    <= L_BALL_Y0;
            r_dx        <= 1'b1;
            r_dy        <= 1'b1;
            r_frame_cnt <= '0;
            r_miss      <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_ball_x    <= w_ball_x_next;
            r_ball_y    <= w_ball_y_next;
            r_dx        <= w_dx_next;
            r_dy        <= w_dy_next;
            r_frame_cnt <= w_cnt_next;
            r_miss      <= w_miss_next;
        end
    end

    // NOTE: every output of this block is defaulted first, so no path through
    // the case statement can leave one unassigned and infer a latch.
    always_comb begin
        w_state_next  = r_state;
        w_ball_x_next = r_ball_x;
        w_ball_y_next = r_ball_y;
        w_dx_next     = r_dx;
        w_dy_next     = r_dy;
        w_cnt_next    = r_frame_cnt;
        w_miss_next   = 1'b0;

        case (r_state)
            PLAY: begin
                if (w_frame_evt) begin
                    w_dx_next     = w_dx_new;
                    w_dy_next     = w_dy_new;
                    w_ball_x_next = w_x_moved;
                    w_ball_y_next = w_y_moved;
                    if (w_x_moved >= L_MISS_X) begin
                        w_miss_next  = 1'b1;
                        w_cnt_next   = '0;
                        w_state_next = MISS_WAIT;
                    end
                end
            end
            MISS_WAIT: begin
                if (w_frame_evt) begin
                    if (r_frame_cnt == L_CNT_LAST) begin
                        w_state_next  = PLAY;
                        w_ball_x_next = L_BALL_X0;
                        w_ball_y_next = L_BALL_Y0;
                        w_dx_next     = 1'b1;
                        w_dy_next     = 1'b1;
                    end else begin
                        w_cnt_next = r_frame_cnt + 1'b1;
                    end
                end
            end
            default: w_state_next = PLAY;
        endcase
    end

    // Render path: reads the live game registers, so a coincident frame update
    // simply shows up on the following pixel.
    assign w_wall_px  = (x >= L_WALL_X_L) && (x <= L_WALL_X_R);
    assign w_pad_px   = (x >= L_PAD_X_L) && (x <= L_PAD_X_R)
                     && (y >= r_pad_y) && (y <= r_pad_y + L_PAD_EXT);
    assign w_ball_box = (r_state == PLAY)
                     && (x >= r_ball_x) && (x <= w_ball_x_r)
                     && (y >= r_ball_y) && (y <= w_ball_y_b);

`ifdef BALL_ROUND_EN
    logic [2:0] w_mask_row;
    logic [2:0] w_mask_col;
    logic [7:0] w_mask;

    assign w_mask_row = 3'(y - r_ball_y);
    assign w_mask_col = 3'(x - r_ball_x);

    ball_rom u_ball_rom (
        .i_row  (w_mask_row),
        .o_mask (w_mask)
    );

    assign w_ball_px = w_ball_box && w_mask[3'd7 - w_mask_col];
`else
    assign w_ball_px = w_ball_box;
`endif

    always_comb begin
        w_colour = COL_BG;
        if (w_wall_px) begin
            w_colour = COL_WALL;
        end else if (w_pad_px) begin
            w_colour = COL_PAD;
        end else if (w_ball_px) begin
            w_colour = COL_BALL;
        end
    end

    always_ff @(posedge clk_100MHz or negedge reset_n) begin
        if (!reset_n) begin
            r_rgb <= COL_BG;
        end else if (p_tick) begin
            r_rgb <= video_on ? w_colour : COL_BG;
        end
    end

    assign rgb  = r_rgb;
    assign miss = r_miss;

endmodule

// File: tb/tb_pixel_gen_ball.sv
// Self-checking bench for pixel_gen_ball: randomized frames and pixel probes
// compared against an integer-arithmetic game model.
module tb_pixel_gen_ball;

    logic        clk_100MHz = 1'b0;
    logic        reset_n;
    logic        video_on;
    logic        p_tick;
    logic        refresh_tick;
    logic [9:0]  x;
    logic [9:0]  y;
    logic        btn_up;
    logic        btn_down;
    logic [11:0] rgb;
    logic        miss;

    int n_checks = 0;
    int n_fail   = 0;

    // Game model
    int m_bx, m_by, m_pad, m_cnt;
    bit m_dx, m_dy, m_play, m_missed;

`ifdef BALL_ROUND_EN
    bit [7:0] ball_mask [8] = '{8'h3C, 8'h7E, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h7E, 8'h3C};
`endif

    pixel_gen_ball dut (
        .clk_100MHz   (clk_100MHz),
        .reset_n      (reset_n),
        .video_on     (video_on),
        .p_tick       (p_tick),
        .refresh_tick (refresh_tick),
        .x            (x),
        .y            (y),
        .btn_up       (btn_up),
        .btn_down     (btn_down),
        .rgb          (rgb),
        .miss         (miss)
    );

    always #5 clk_100MHz = ~clk_100MHz;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    function automatic void model_reset();
        m_bx = 320; m_by = 240; m_dx = 1; m_dy = 1;
        m_pad = 204; m_play = 1; m_cnt = 0; m_missed = 0;
    endfunction

    function automatic void model_frame(input bit up, input bit down);
        int old_pad = m_pad;
        m_missed = 0;
        if (up && !down)      m_pad = (m_pad >= 3) ? m_pad - 3 : 0;
        else if (down && !up) m_pad = (m_pad + 3 > 408) ? 408 : m_pad + 3;
        if (m_play) begin
            if (m_by <= 2)            m_dy = 1;
            else if (m_by + 8 >= 478) m_dy = 0;
            if (m_bx <= 42) m_dx = 1;
            else if (m_bx + 7 >= 598 && m_bx + 7 <= 603 &&
                     m_by <= old_pad + 71 && m_by + 7 >= old_pad) m_dx = 0;
            m_bx += m_dx ? 2 : -2;
            m_by += m_dy ? 2 : -2;
            if (m_bx + 8 >= 640) begin
                m_missed = 1; m_play = 0; m_cnt = 0;
            end
        end else begin
            m_cnt++;
            if (m_cnt == 60) begin
                m_play = 1; m_bx = 320; m_by = 240; m_dx = 1; m_dy = 1;
            end
        end
    endfunction

    function automatic logic [11:0] model_pixel(input int px, input int py, input bit von);
        bit in_ball;
        if (!von) return 12'h000;
        if (px >= 32 && px <= 39) return 12'h00F;
        if (px >= 600 && px <= 603 && py >= m_pad && py < m_pad + 72) return 12'h0F0;
        in_ball = m_play && px >= m_bx && px < m_bx + 8 && py >= m_by && py < m_by + 8;
`ifdef BALL_ROUND_EN
        if (in_ball) in_ball = ball_mask[py - m_by][7 - (px - m_bx)];
`endif
        return in_ball ? 12'hF00 : 12'h000;
    endfunction

    task automatic probe(input string tag, input int px, input int py, input bit von);
        @(negedge clk_100MHz);
        p_tick = 1'b1; video_on = von; x = 10'(px); y = 10'(py);
        @(negedge clk_100MHz);
        p_tick = 1'b0;
        check(tag, rgb, model_pixel(px, py, von));
    endtask

    task automatic do_frame(input bit up, input bit down, input int hold);
        int pulses = 0;
        @(negedge clk_100MHz);
        btn_up = up; btn_down = down;
        repeat (3) @(negedge clk_100MHz);
        refresh_tick = 1'b1;
        for (int i = 0; i < hold + 3; i++) begin
            @(negedge clk_100MHz);
            if (i == hold - 1) refresh_tick = 1'b0;
            pulses += int'(miss);
        end
        model_frame(up, down);
        check("miss_pulse", pulses, m_missed ? 1 : 0);
        check("pad_y", dut.r_pad_y, m_pad);
        if (m_play) begin
            check("ball_x", dut.r_ball_x, m_bx);
            check("ball_y", dut.r_ball_y, m_by);
        end
        check("ball_y_max", dut.r_ball_y <= 10'd472, 1);
    endtask

    task automatic random_probes();
        probe("px_rand", $urandom_range(639), $urandom_range(479), 1'b1);
        probe("px_ball", m_bx + $urandom_range(7), m_by + $urandom_range(7), 1'b1);
        probe("px_pad", 600 + $urandom_range(3), m_pad + $urandom_range(80), 1'b1);
    endtask

    initial begin
        int guard;
        int hidden;
        int saved_pad;

        reset_n = 1'b0; video_on = 1'b0; p_tick = 1'b0; refresh_tick = 1'b0;
        x = '0; y = '0; btn_up = 1'b0; btn_down = 1'b0;
        model_reset();

        // Reset state
        repeat (5) @(negedge clk_100MHz);
        check("rst_rgb", rgb, 12'h000);
        check("rst_miss", miss, 1'b0);
        check("rst_ball_x", dut.r_ball_x, 320);
        check("rst_ball_y", dut.r_ball_y, 240);
        check("rst_pad_y", dut.r_pad_y, 204);
        reset_n = 1'b1;

        // Render: wall, paddle, blanking, p_tick gating
        probe("wall", 35, 100, 1'b1);
        @(negedge clk_100MHz);
        x = 10'd0; y = 10'd0; video_on = 1'b1; p_tick = 1'b0;
        @(negedge clk_100MHz);
        check("hold_no_ptick", rgb, 12'h00F);
        probe("paddle", 601, 210, 1'b1);
        probe("wall_blank", 35, 100, 1'b0);
        probe("paddle_blank", 601, 210, 1'b0);
        probe("ball_centre", 324, 244, 1'b1);
        probe("ball_corner0", 320, 240, 1'b1);

        // A long refresh_tick is still one frame
        do_frame(1'b0, 1'b0, 4);
        check("step_x", dut.r_ball_x, 322);
        check("step_y", dut.r_ball_y, 242);

        // Random frames and pixels
        for (int i = 0; i < 40; i++) begin
            do_frame(1'($urandom_range(1)), 1'($urandom_range(1)), 1 + $urandom_range(5));
            random_probes();
        end

        // Paddle saturation at both ends, then both buttons
        for (int i = 0; i < 100; i++) do_frame(1'b1, 1'b0, 1 + $urandom_range(3));
        check("pad_top", dut.r_pad_y, 0);
        for (int i = 0; i < 200; i++) do_frame(1'b0, 1'b1, 1 + $urandom_range(3));
        check("pad_bottom", dut.r_pad_y, 408);
        saved_pad = m_pad;
        for (int i = 0; i < 10; i++) do_frame(1'b1, 1'b1, 1 + $urandom_range(3));
        check("pad_both", dut.r_pad_y, saved_pad);

        // Park paddle at top and wait for a clean miss
        guard = 0;
        while (!m_play && guard < 100) begin
            do_frame(1'b1, 1'b0, 1); guard++;
        end
        guard = 0;
        while (m_play && guard < 2500) begin
            do_frame(1'b1, 1'b0, 1 + $urandom_range(3)); guard++;
        end
        if (m_play) begin
            check("miss_timeout", 0, 1);
        end else begin
            hidden = 0;
            while (!m_play && hidden < 100) begin
                probe("hidden_ball", m_bx + $urandom_range(7), m_by + $urandom_range(7), 1'b1);
                do_frame(1'b1, 1'b0, 1 + $urandom_range(3));
                hidden++;
            end
            check("hidden_frames", hidden, 60);
            check("respawn_x", dut.r_ball_x, 320);
            check("respawn_y", dut.r_ball_y, 240);
            probe("respawn_corner", m_bx, m_by, 1'b1);
            probe("respawn_centre", m_bx + 4, m_by + 4, 1'b1);
        end

        // Mid-operation asynchronous reset
        for (int i = 0; i < 5; i++) do_frame(1'b0, 1'b1, 2);
        @(negedge clk_100MHz);
        #2 reset_n = 1'b0;
        #1;
        model_reset();
        check("mid_rst_ball_x", dut.r_ball_x, m_bx);
        check("mid_rst_ball_y", dut.r_ball_y, m_by);
        check("mid_rst_pad", dut.r_pad_y, m_pad);
        check("mid_rst_rgb", rgb, 12'h000);
        @(negedge clk_100MHz);
        reset_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            do_frame(1'($urandom_range(1)), 1'($urandom_range(1)), 1 + $urandom_range(5));
            random_probes();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
